// File: rtl/s_mem_phase_arbiter.sv
// rtl/s_mem_phase_arbiter.sv - RC4 phase sequencer and S-memory port arbiter
//
// Sequences the three RC4 phase engines (S-array init, key-schedule shuffle,
// PRGA decrypt). Each engine gets a one-cycle start pulse and exclusive
// ownership of the single-port S-memory until it pulses its done.
//
// Optional feature macro: SMEM_ARB_WATCHDOG_EN
//   Defined: a per-phase cycle counter sends the sequencer to ERROR when a
//   phase lasts TIMEOUT cycles without its done.
//   Undefined: no counter; error is tied low and ERROR is unreachable.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   go, abort                    run start/restart level, stop current run
//   start_init/shuf/dec          one-cycle start pulses to the engines
//   done_init/shuf/dec           completion pulses from the engines
//   grant_init/shuf/dec          ownership grants (one-hot or all zero)
//   req_/addr_/wdata_/wren_x     per-engine memory access request
//   mem_addr/mem_data/mem_wren   muxed S-memory port
//   phase, busy, all_done, error status
module s_mem_phase_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              go,
    input  logic              abort,
    output logic              start_init,
    output logic              start_shuf,
    output logic              start_dec,
    input  logic              done_init,
    input  logic              done_shuf,
    input  logic              done_dec,
    output logic              grant_init,
    output logic              grant_shuf,
    output logic              grant_dec,
    input  logic              req_init,
    input  logic              req_shuf,
    input  logic              req_dec,
    input  logic [ADDR_W-1:0] addr_init,
    input  logic [ADDR_W-1:0] addr_shuf,
    input  logic [ADDR_W-1:0] addr_dec,
    input  logic [DATA_W-1:0] wdata_init,
    input  logic [DATA_W-1:0] wdata_shuf,
    input  logic [DATA_W-1:0] wdata_dec,
    input  logic              wren_init,
    input  logic              wren_shuf,
    input  logic              wren_dec,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic [2:0]        phase,
    output logic              busy,
    output logic              all_done,
    output logic              error
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_SHUF  = 3'd2,
        ST_DEC   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] start_q, start_d;   // bit 0 init, bit 1 shuf, bit 2 dec
    logic       in_phase;
    logic       wd_expired;

    assign in_phase = (state_q == ST_INIT) || (state_q == ST_SHUF) || (state_q == ST_DEC);

`ifdef SMEM_ARB_WATCHDOG_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign wd_expired = in_phase && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Counter restarts on every state change so each phase gets its own budget.
    always_comb begin
        cnt_d = '0;
        if (in_phase && (state_d == state_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // No watchdog: expiry never fires; TIMEOUT stays referenced but inert.
    assign wd_expired = 1'b0 & (TIMEOUT != 0);
`endif

    // Next-state: abort beats everything, the owner's done beats the watchdog,
    // and go only matters while no run is in progress.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (go) state_d = ST_INIT;
                end
                ST_INIT: begin
                    if (done_init)       state_d = ST_SHUF;
                    else if (wd_expired) state_d = ST_ERROR;
                end
                ST_SHUF: begin
                    if (done_shuf)       state_d = ST_DEC;
                    else if (wd_expired) state_d = ST_ERROR;
                end
                ST_DEC: begin
                    if (done_dec)        state_d = ST_DONE;
                    else if (wd_expired) state_d = ST_ERROR;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Start pulse is registered alongside the state so it lands in the
    // first cycle of the newly entered phase.
    always_comb begin
        start_d    = 3'b000;
        start_d[0] = (state_d == ST_INIT) && (state_q != ST_INIT);
        start_d[1] = (state_d == ST_SHUF) && (state_q != ST_SHUF);
        start_d[2] = (state_d == ST_DEC)  && (state_q != ST_DEC);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            start_q <= 3'b000;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
        end
    end

    assign start_init = start_q[0];
    assign start_shuf = start_q[1];
    assign start_dec  = start_q[2];

    assign grant_init = (state_q == ST_INIT);
    assign grant_shuf = (state_q == ST_SHUF);
    assign grant_dec  = (state_q == ST_DEC);

    // Mux selects on registered state only, so ownership cannot change mid-cycle.
    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
        case (state_q)
            ST_INIT: begin
                mem_addr = addr_init;
                mem_data = wdata_init;
                mem_wren = req_init & wren_init;
            end
            ST_SHUF: begin
                mem_addr = addr_shuf;
                mem_data = wdata_shuf;
                mem_wren = req_shuf & wren_shuf;
            end
            ST_DEC: begin
                mem_addr = addr_dec;
                mem_data = wdata_dec;
                mem_wren = req_dec & wren_dec;
            end
            default: begin
                mem_addr = '0;
                mem_data = '0;
                mem_wren = 1'b0;
            end
        endcase
    end

    assign phase    = state_q;
    assign busy     = in_phase;
    assign all_done = (state_q == ST_DONE);
    assign error    = (state_q == ST_ERROR);

endmodule

// File: tb/tb_s_mem_phase_arbiter.sv
// tb/tb_s_mem_phase_arbiter.sv - self-checking bench for s_mem_phase_arbiter
module tb_s_mem_phase_arbiter;

`ifdef SMEM_ARB_WATCHDOG_EN
    localparam int TB_TIMEOUT = 16;
    localparam int D_INIT = 8;
    localparam int D_SHUF = 12;
    localparam int D_DEC  = 5;
`else
    localparam int TB_TIMEOUT = 16;
    localparam int D_INIT = 256;
    localparam int D_SHUF = 768;
    localparam int D_DEC  = 300;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       go, abort;
    logic [2:0] done_v, req_v, wren_v;
    logic [7:0] addr_v [3];
    logic [7:0] wdata_v [3];

    logic       start_init, start_shuf, start_dec;
    logic       grant_init, grant_shuf, grant_dec;
    logic [7:0] mem_addr, mem_data;
    logic       mem_wren;
    logic [2:0] phase;
    logic       busy, all_done, error;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: phase number 0..5, which phase's start is pulsing
    // (0 = none), cycles spent in the current phase.
    int m_phase = 0;
    int m_start = 0;
    int m_cnt   = 0;

    always #5 clk = ~clk;

    s_mem_phase_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .go(go), .abort(abort),
        .start_init(start_init), .start_shuf(start_shuf), .start_dec(start_dec),
        .done_init(done_v[0]), .done_shuf(done_v[1]), .done_dec(done_v[2]),
        .grant_init(grant_init), .grant_shuf(grant_shuf), .grant_dec(grant_dec),
        .req_init(req_v[0]), .req_shuf(req_v[1]), .req_dec(req_v[2]),
        .addr_init(addr_v[0]), .addr_shuf(addr_v[1]), .addr_dec(addr_v[2]),
        .wdata_init(wdata_v[0]), .wdata_shuf(wdata_v[1]), .wdata_dec(wdata_v[2]),
        .wren_init(wren_v[0]), .wren_shuf(wren_v[1]), .wren_dec(wren_v[2]),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .phase(phase), .busy(busy), .all_done(all_done), .error(error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Phases 1..3 are engine phases; engine index is phase-1.
    task automatic model_edge();
        int nxt;
        nxt = m_phase;
        if (abort) begin
            nxt = 0;
        end else if (m_phase >= 1 && m_phase <= 3) begin
            if (done_v[m_phase-1]) nxt = m_phase + 1;
`ifdef SMEM_ARB_WATCHDOG_EN
            else if (m_cnt == TB_TIMEOUT - 1) nxt = 5;
`endif
        end else if (go) begin
            nxt = 1;
        end
        m_start = (nxt >= 1 && nxt <= 3 && nxt != m_phase) ? nxt : 0;
        m_cnt   = (nxt != m_phase) ? 0 : m_cnt + 1;
        m_phase = nxt;
    endtask

    task automatic check_all(input string tag);
        int own;
        own = (m_phase >= 1 && m_phase <= 3) ? m_phase - 1 : -1;
        chk({tag, ":phase"},      32'(phase),      32'(m_phase));
        chk({tag, ":start_init"}, 32'(start_init), 32'(m_start == 1));
        chk({tag, ":start_shuf"}, 32'(start_shuf), 32'(m_start == 2));
        chk({tag, ":start_dec"},  32'(start_dec),  32'(m_start == 3));
        chk({tag, ":grants"}, 32'({grant_dec, grant_shuf, grant_init}),
            32'((own >= 0) ? (1 << own) : 0));
        chk({tag, ":busy"},     32'(busy),     32'(own >= 0));
        chk({tag, ":all_done"}, 32'(all_done), 32'(m_phase == 4));
        chk({tag, ":error"},    32'(error),    32'(m_phase == 5));
        if (own >= 0) begin
            chk({tag, ":mem_addr"}, 32'(mem_addr), 32'(addr_v[own]));
            chk({tag, ":mem_data"}, 32'(mem_data), 32'(wdata_v[own]));
            chk({tag, ":mem_wren"}, 32'(mem_wren), 32'(req_v[own] & wren_v[own]));
        end else begin
            chk({tag, ":mem_addr"}, 32'(mem_addr), 32'd0);
            chk({tag, ":mem_data"}, 32'(mem_data), 32'd0);
            chk({tag, ":mem_wren"}, 32'(mem_wren), 32'd0);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic clr();
        go = 1'b0; abort = 1'b0;
        done_v = 3'b000; req_v = 3'b000; wren_v = 3'b000;
        for (int i = 0; i < 3; i++) begin
            addr_v[i] = 8'h00; wdata_v[i] = 8'h00;
        end
    endtask

    task automatic pulse_go(input string tag);
        go = 1'b1; step(tag); go = 1'b0;
    endtask

    task automatic pulse_done(input int e, input string tag);
        done_v[e] = 1'b1; step(tag); done_v[e] = 1'b0;
    endtask

    task automatic to_idle();
        abort = 1'b1; step("to_idle"); abort = 1'b0;
    endtask

    initial begin
        clr();
        reset_n = 1'b0;
        #3;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;
        step("idle");

        // Normal run
        pulse_go("go");
        chk("start_init_pulse", 32'(start_init), 32'd1);
        steps(D_INIT - 1, "run_init");
        pulse_done(0, "done_init");
        chk("phase_shuf", 32'(phase), 32'd2);
        steps(D_SHUF - 1, "run_shuf");
        pulse_done(1, "done_shuf");
        chk("phase_dec", 32'(phase), 32'd3);
        steps(D_DEC - 1, "run_dec");
        pulse_done(2, "done_dec");
        chk("all_done", 32'(all_done), 32'd1);
        steps(3, "hold_done");

        // Restart from DONE
        pulse_go("go_in_done");
        chk("restart_phase", 32'(phase), 32'd1);
        chk("restart_start", 32'(start_init), 32'd1);

        // go held during INIT gives no second start
        go = 1'b1;
        steps(4, "go_held");
        chk("no_second_start", 32'(start_init), 32'd0);
        go = 1'b0;

        // Stray done during INIT, then done_init with abort
        pulse_done(2, "stray_done_dec");
        chk("stray_phase", 32'(phase), 32'd1);
        done_v[0] = 1'b1; abort = 1'b1;
        step("done_abort");
        done_v[0] = 1'b0; abort = 1'b0;
        chk("abort_phase", 32'(phase), 32'd0);
        chk("abort_grants", 32'({grant_dec, grant_shuf, grant_init}), 32'd0);

        // Isolation in SHUF
        pulse_go("iso_go");
        pulse_done(0, "iso_to_shuf");
        req_v = 3'b011; wren_v = 3'b011;
        addr_v[0] = 8'h10; addr_v[1] = 8'h20; wdata_v[1] = 8'hA5;
        #1;
        chk("iso_addr", 32'(mem_addr), 32'h20);
        chk("iso_data", 32'(mem_data), 32'hA5);
        chk("iso_wren", 32'(mem_wren), 32'd1);
        req_v[1] = 1'b0;
        #1;
        chk("iso_noreq", 32'(mem_wren), 32'd0);
        req_v[1] = 1'b1;
        steps(2, "iso_hold");

        // Asynchronous reset mid-SHUF
        #2;
        reset_n = 1'b0;
        #1;
        m_phase = 0; m_start = 0; m_cnt = 0;
        check_all("reset_mid");
        @(negedge clk);
        reset_n = 1'b1;
        clr();
        step("after_reset");

        // Watchdog
        req_v[0] = 1'b1; wren_v[0] = 1'b1; addr_v[0] = 8'h33;
        pulse_go("wd_go");
        steps(15, "wd_wait");
`ifdef SMEM_ARB_WATCHDOG_EN
        chk("wd_still_init", 32'(phase), 32'd1);
        step("wd_expire");
        chk("wd_phase", 32'(phase), 32'd5);
        chk("wd_error", 32'(error), 32'd1);
        chk("wd_wren", 32'(mem_wren), 32'd0);
        to_idle();
        pulse_go("wd2_go");
        steps(15, "wd2_wait");
        pulse_done(0, "wd2_done_at_limit");
        chk("wd2_phase", 32'(phase), 32'd2);
`else
        steps(5, "nowd_wait");
        chk("nowd_phase", 32'(phase), 32'd1);
        chk("nowd_error", 32'(error), 32'd0);
`endif
        to_idle();
        clr();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            go     = ($urandom % 8) == 0;
            abort  = ($urandom % 64) == 0;
            done_v = {($urandom % 12) == 0, ($urandom % 12) == 0, ($urandom % 12) == 0};
            req_v  = 3'($urandom);
            wren_v = 3'($urandom);
            for (int i = 0; i < 3; i++) begin
                addr_v[i]  = 8'($urandom);
                wdata_v[i] = 8'($urandom);
            end
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
